// File: rtl/sap_uart_pkg.sv
// Shared types and constants for the OUT-port UART transmitter.
package sap_uart_pkg;

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

   localparam int   UART_DATA_BITS  = 8;
   localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a pop on an empty FIFO is ignored and
// a push is accepted when full only if a pop frees a slot on the same edge.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == CW'(0));
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   // Storage, pointers and occupancy
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= AW'(0);
         rd_ptr <= AW'(0);
         count  <= CW'(0);
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= WIDTH'(0);
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/out_port_uart_tx.sv
// Buffers bytes strobed out of the computer's OUT register and sends them as
// 8N1 UART frames, back-to-back when the FIFO has more queued.
module out_port_uart_tx
   import sap_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 104,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] out_val,
   input  logic       out_load,
   output logic       tx,
   output logic       busy,
   output logic       fifo_full,
   output logic       overflow
);

   localparam int BW = $clog2(CLKS_PER_BIT);

   tx_state_t                   state;
   logic [BW-1:0]               baud_cnt;
   logic [2:0]                  bit_idx;
   logic [UART_DATA_BITS-1:0]   shift;
   logic [UART_DATA_BITS-1:0]   fifo_dout;
   logic                        fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   logic                        baud_last;
   logic                        pop;

   assign baud_last = (baud_cnt == BW'(CLKS_PER_BIT - 1));
   // The FIFO head is consumed either straight from idle or at the very end of a stop bit.
   assign pop  = ~fifo_empty & ((state == TX_IDLE) | ((state == TX_STOP) & baud_last));
   assign busy = (state != TX_IDLE) | (fifo_count != '0);

   sync_fifo #(
      .WIDTH (UART_DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (out_load),
      .pop   (pop),
      .din   (out_val),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Framing FSM; tx is registered so the line never glitches
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= TX_IDLE;
         tx       <= UART_IDLE_LEVEL;
         baud_cnt <= BW'(0);
         bit_idx  <= 3'd0;
         shift    <= '0;
      end else begin
         case (state)
            TX_IDLE: begin
               baud_cnt <= BW'(0);
               tx       <= UART_IDLE_LEVEL;
               if (pop) begin
                  shift <= fifo_dout;
                  state <= TX_START;
                  tx    <= 1'b0;
               end
            end
            TX_START: begin
               if (baud_last) begin
                  baud_cnt <= BW'(0);
                  bit_idx  <= 3'd0;
                  state    <= TX_DATA;
                  tx       <= shift[0];
               end else begin
                  baud_cnt <= baud_cnt + BW'(1);
               end
            end
            TX_DATA: begin
               if (baud_last) begin
                  baud_cnt <= BW'(0);
                  if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
                     state <= TX_STOP;
                     tx    <= UART_IDLE_LEVEL;
                  end else begin
                     shift   <= shift >> 1;
                     bit_idx <= bit_idx + 3'd1;
                     tx      <= shift[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + BW'(1);
               end
            end
            TX_STOP: begin
               if (baud_last) begin
                  baud_cnt <= BW'(0);
                  if (pop) begin
                     shift <= fifo_dout;
                     state <= TX_START;
                     tx    <= 1'b0;
                  end else begin
                     state <= TX_IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + BW'(1);
               end
            end
            default: begin
               state    <= TX_IDLE;
               tx       <= UART_IDLE_LEVEL;
               baud_cnt <= BW'(0);
            end
         endcase
      end
   end

   // Sticky record of a strobe lost to a full FIFO
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow <= 1'b0;
      end else if (out_load & fifo_full & ~pop) begin
         overflow <= 1'b1;
      end else begin
         overflow <= overflow;
      end
   end

endmodule

// File: tb/tb_out_port_uart_tx.sv
// Scoreboard bench: stimulus queues expected bytes, a UART monitor decodes tx and compares.
module tb_out_port_uart_tx;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] out_val = 8'h00;
   logic       out_load = 1'b0;
   logic       tx;
   logic       busy;
   logic       fifo_full;
   logic       overflow;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc = 0;
   logic [7:0] exp_q[$];
   int         start_cycles[$];

   out_port_uart_tx #(
      .CLKS_PER_BIT (4),
      .FIFO_DEPTH   (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .out_val   (out_val),
      .out_load  (out_load),
      .tx        (tx),
      .busy      (busy),
      .fifo_full (fifo_full),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic send(input logic [7:0] v, input bit expect_rx);
      @(negedge clk);
      out_val  = v;
      out_load = 1'b1;
      if (expect_rx) exp_q.push_back(v);
      @(negedge clk);
      out_load = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      int k;
      k = 0;
      while (busy && k < limit) begin
         @(negedge clk);
         k++;
      end
      chk("idle_timeout", busy, 0);
      repeat (3) @(negedge clk);
   endtask

   task automatic mon_wait(input int n, output bit ab);
      ab = 1'b0;
      repeat (n) begin
         @(negedge clk);
         if (reset) ab = 1'b1;
      end
   endtask

   // UART receiver: samples each bit mid-period, abandons a frame cut by reset
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (!reset && tx === 1'b0) begin
            bit         ab;
            logic [7:0] b;
            b = 8'h00;
            start_cycles.push_back(cyc);
            mon_wait(2, ab);
            if (!ab) chk("start_bit", tx, 0);
            for (int i = 0; i < 8 && !ab; i++) begin
               mon_wait(4, ab);
               b[i] = tx;
            end
            if (!ab) mon_wait(4, ab);
            if (!ab) begin
               chk("stop_bit", tx, 1);
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_frame: got %0h expected no frame", b);
               end else begin
                  chk("rx_byte", b, exp_q.pop_front());
               end
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "simulation timeout");
   end

   initial begin : stim
      int k;
      int s0;

      // Reset held three cycles
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_tx", tx, 1);
         chk("rst_busy", busy, 0);
         chk("rst_full", fifo_full, 0);
         chk("rst_ovf", overflow, 0);
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle_tx", tx, 1);

      // Single byte, busy spans one frame plus the enqueue cycle
      send(8'h44, 1'b1);
      k = 1;
      chk("busy_after_load", busy, 1);
      while (busy && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("busy_cycles", k, 42);
      repeat (3) @(negedge clk);

      // Two strobes two cycles apart give contiguous frames
      s0 = start_cycles.size();
      send(8'h44, 1'b1);
      send(8'h22, 1'b1);
      wait_idle(300);
      chk("b2b_frames", start_cycles.size() - s0, 2);
      if (start_cycles.size() - s0 == 2)
         chk("b2b_spacing", start_cycles[s0+1] - start_cycles[s0], 40);

      // Six consecutive strobes: one in flight, four buffered, last dropped
      for (int v = 1; v <= 6; v++) begin
         @(negedge clk);
         out_val  = 8'(v);
         out_load = 1'b1;
         if (v <= 5) exp_q.push_back(8'(v));
      end
      @(negedge clk);
      out_load = 1'b0;
      chk("burst_full", fifo_full, 1);
      chk("burst_ovf", overflow, 1);
      wait_idle(1000);
      chk("ovf_sticky", overflow, 1);
      chk("drained_full", fifo_full, 0);

      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("ovf_cleared", overflow, 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Push into a full FIFO on the edge where the stop bit pops
      for (int c = 0; c <= 41; c++) begin
         @(negedge clk);
         if (c == 41) begin
            chk("pre_pop_full", fifo_full, 1);
            chk("pre_pop_ovf", overflow, 0);
         end
         out_load = (c < 5 || c == 41);
         out_val  = (c < 5) ? 8'(8'h11 + c) : 8'h16;
         if (c < 5 || c == 41) exp_q.push_back(out_val);
      end
      @(negedge clk);
      out_load = 1'b0;
      chk("pushpop_ovf", overflow, 0);
      chk("pushpop_full", fifo_full, 1);
      wait_idle(1500);
      chk("pushpop_ovf_end", overflow, 0);

      // Reset in the middle of the data bits of 8'hA5
      send(8'hA5, 1'b0);
      repeat (15) @(negedge clk);
      chk("mid_busy", busy, 1);
      reset = 1'b1;
      #1;
      chk("abort_tx", tx, 1);
      chk("abort_busy", busy, 0);
      chk("abort_full", fifo_full, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      send(8'h3C, 1'b1);
      wait_idle(300);

      chk("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
